// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: ALUControl op codes, FSM states and
// op-class helpers used by alu_seq and alu_comb.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_XOR  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_BGE  = 4'b1010,
    ALU_BGEU = 4'b1011,
    ALU_BNE  = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRA) || (code == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU: operand request channel in,
// result channel out.
interface alu_seq_if #(
  parameter int XLEN = 32
);
  // Both channels: a transfer happens on a rising clock edge where valid and
  // ready are both high; the sender holds its payload until that edge.
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_ctrl, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_ctrl, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_comb.sv
// Single-cycle evaluation of every non-shift ALUControl op plus the
// undefined-code flag. Shift codes yield 0 here; alu_seq produces them.
module alu_comb
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  logic lt_s;
  logic lt_u;

  assign lt_s = $signed(src_a) < $signed(src_b);
  assign lt_u = src_a < src_b;

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alu_ctrl)
      ALU_ADD:  result = src_a + src_b;
      ALU_SUB:  result = src_a - src_b;
      ALU_AND:  result = src_a & src_b;
      ALU_OR:   result = src_a | src_b;
      ALU_XOR:  result = src_a ^ src_b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
      ALU_BGE:  result = {{(XLEN-1){1'b0}}, ~lt_s};
      ALU_BGEU: result = {{(XLEN-1){1'b0}}, ~lt_u};
      ALU_BNE:  result = {{(XLEN-1){1'b0}}, (src_a != src_b)};
      ALU_SLL, ALU_SRA, ALU_SRL: result = '0;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute unit: FSM, shift counter and handshakes around alu_comb.
// Build option ALU_SEQ_FAST_SHIFT_EN swaps the 1-bit/cycle shifter for a barrel shifter.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  alu_seq_if.slave   bus,
  output state_e     dbg_state
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  state_e          state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic [3:0]      shop_q, shop_d;

  logic [XLEN-1:0] comb_result;
  logic            comb_illegal;
  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] step_val;

  alu_comb #(.XLEN(XLEN)) u_comb (
    .alu_ctrl (bus.alu_ctrl),
    .src_a    (bus.src_a),
    .src_b    (bus.src_b),
    .result   (comb_result),
    .illegal  (comb_illegal)
  );

  function automatic logic [XLEN-1:0] shift_one(input logic [XLEN-1:0] v, input logic [3:0] op);
    case (op)
      ALU_SLL: return {v[XLEN-2:0], 1'b0};
      ALU_SRA: return {v[XLEN-1], v[XLEN-1:1]};
      default: return {1'b0, v[XLEN-1:1]};
    endcase
  endfunction

  assign bus.in_ready = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign shamt        = bus.src_b[SHW-1:0];
  assign step_val     = shift_one(result_q, shop_q);

`ifdef ALU_SEQ_FAST_SHIFT_EN
  logic [XLEN-1:0] barrel_val;

  always_comb begin
    barrel_val = '0;
    case (bus.alu_ctrl)
      ALU_SLL: barrel_val = bus.src_a << shamt;
      ALU_SRA: barrel_val = $signed(bus.src_a) >>> shamt;
      default: barrel_val = bus.src_a >> shamt;
    endcase
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    shop_d    = shop_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SHIFT: begin
          // result_q doubles as the working register while shifting
          result_d = step_val;
          cnt_d    = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = DONE;
            zero_d  = (step_val == '0);
          end
        end
        IDLE, DONE: begin
          if (accept) begin
            if (is_shift(bus.alu_ctrl)) begin
              illegal_d = 1'b0;
`ifdef ALU_SEQ_FAST_SHIFT_EN
              result_d = barrel_val;
              zero_d   = (barrel_val == '0);
              state_d  = DONE;
`else
              result_d = bus.src_a;
              if (shamt == '0) begin
                zero_d  = (bus.src_a == '0);
                state_d = DONE;
              end else begin
                zero_d  = 1'b0;
                cnt_d   = shamt;
                shop_d  = bus.alu_ctrl;
                state_d = SHIFT;
              end
`endif
            end else begin
              result_d  = comb_result;
              zero_d    = (comb_result == '0);
              illegal_d = comb_illegal;
              state_d   = DONE;
            end
          end else if ((state_q == DONE) && bus.out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      shop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      shop_q    <= shop_d;
    end
  end

  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq: expected responses are queued
// at accept time and popped by a monitor whenever a result is transferred.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int XLEN = 32;
  localparam int W    = XLEN + 2;

  logic   clk;
  logic   reset;
  logic   flush;
  state_e dbg_state;

  alu_seq_if #(.XLEN(XLEN)) bus ();

  alu_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: {result, zero, illegal} straight from the op table.
  function automatic logic [W-1:0] model(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic ill;
    int unsigned sh;
    r = '0;
    ill = 1'b0;
    sh = b % XLEN;
    case (c)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a << sh;
      4'd5:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd6:  r = (a < b) ? 1 : 0;
      4'd7:  r = a ^ b;
      4'd8:  r = $signed(a) >>> sh;
      4'd9:  r = a >> sh;
      4'd10: r = ($signed(a) >= $signed(b)) ? 1 : 0;
      4'd11: r = (a >= b) ? 1 : 0;
      4'd12: r = (a != b) ? 1 : 0;
      default: ill = 1'b1;
    endcase
    return {r, (r == '0), ill};
  endfunction

  function automatic int exp_lat(input logic [3:0] c, input logic [XLEN-1:0] b);
`ifdef ALU_SEQ_FAST_SHIFT_EN
    return 1;
`else
    if ((c == 4'd4 || c == 4'd8 || c == 4'd9) && (b % XLEN) != 0)
      return 1 + int'(b % XLEN);
    return 1;
`endif
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input bit push, output int waited);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = c;
    bus.src_a    = a;
    bus.src_b    = b;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited <= 500) begin
      @(negedge clk);
      waited++;
    end
    check("accept_timeout", 64'(waited > 500), 64'd0);
    @(posedge clk);
    if (push) exp_q.push_back(model(c, a, b));
    #1;
    bus.in_valid = 1'b0;
    bus.alu_ctrl = 4'($urandom_range(0, 15));
    bus.src_a    = $urandom;
    bus.src_b    = $urandom;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string name, input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int waited;
    int lat;
    issue(c, a, b, 1'b1, waited);
    wait_out(lat);
    check({name, "_latency"}, 64'(lat), 64'(exp_lat(c, b)));
  endtask

  task automatic monitor_loop();
    logic [W-1:0] got;
    logic [W-1:0] exp;
    logic [W-1:0] prev;
    bit prev_hold;
    prev_hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      got = {bus.result, bus.zero, bus.illegal};
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold && bus.out_valid) check("hold_stable", 64'(got), 64'(prev));
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got %h expected no transfer at %0t", got, $time);
          end else begin
            exp = exp_q.pop_front();
            check("scoreboard", 64'(got), 64'(exp));
          end
        end
        prev_hold = bus.out_valid && !bus.out_ready;
        prev = got;
      end
    end
  endtask

  initial begin
    int waited;
    int lat;
    int seen;
    bit rnd_done;

    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = '0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.out_ready = 1'b1;
    fork monitor_loop(); join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_zero", 64'(bus.zero), 64'd0);
    check("rst_illegal", 64'(bus.illegal), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk);
    #1;

    run_one("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1);
    run_one("sra4", 4'd8, 32'h8000_0000, 32'd4);
    run_one("srl4", 4'd9, 32'h8000_0000, 32'd4);
    run_one("sll31", 4'd4, 32'h0000_0003, 32'd31);
    run_one("sll_shamt0", 4'd4, 32'h0000_1234, 32'd32);
    run_one("bge", 4'd10, 32'hFFFF_FFFE, 32'd1);
    run_one("bgeu", 4'd11, 32'hFFFF_FFFE, 32'd1);
    run_one("bne_eq", 4'd12, 32'd7, 32'd7);
    run_one("slt", 4'd5, 32'hFFFF_FFFE, 32'd1);
    run_one("sltu", 4'd6, 32'hFFFF_FFFE, 32'd1);
    run_one("sub", 4'd1, 32'd5, 32'd9);
    run_one("illegal", 4'b1110, 32'h1234_5678, 32'd3);

    // Back-to-back: hold DONE under backpressure, then release with a new op
    bus.out_ready = 1'b0;
    issue(4'd0, 32'd5, 32'd6, 1'b1, waited);
    wait_out(lat);
    check("b2b_first_latency", 64'(lat), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("b2b_hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("b2b_hold_out_valid", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    issue(4'd7, 32'h0000_F0F0, 32'h0000_0FF0, 1'b1, waited);
    check("b2b_no_bubble", 64'(waited), 64'd0);
    wait_out(lat);
    check("b2b_second_latency", 64'(lat), 64'd1);

    // Flush while an sll by 20 is in flight
    bus.out_ready = 1'b0;
    issue(4'd4, 32'd1, 32'd20, 1'b0, waited);
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_state", 64'(dbg_state), 64'(IDLE));
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("flush_no_result", 64'(seen), 64'd0);

    // Accept coinciding with flush is dropped
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.alu_ctrl = 4'd0;
    bus.src_a    = 32'd3;
    bus.src_b    = 32'd4;
    flush        = 1'b1;
    @(negedge clk);
    check("flush_acc_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("flush_acc_dropped", 64'(seen), 64'd0);
    @(posedge clk);
    #1;

    // Random ops with random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          issue(4'($urandom_range(0, 15)), $urandom, $urandom, 1'b1, waited);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    check("random_drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a long shift
    bus.out_ready = 1'b0;
    issue(4'd8, 32'hFFFF_0000, 32'd30, 1'b0, waited);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_result", 64'(bus.result), 64'd0);
    check("arst_zero", 64'(bus.zero), 64'd0);
    check("arst_illegal", 64'(bus.illegal), 64'd0);
    check("arst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    run_one("post_reset_xor", 4'd7, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
